hmac_sha256_164_ctrl: RTL and testbench

//  Sequences one shared SHA-256 compression core through HMAC-SHA256 with an 80B key and an 84B message.
//  The 1312-bit input is split as key = data[1311:672] and msg = data[671:0].

---
 rtl/hmac_sha256_164_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_hmac_sha256_164_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hmac_sha256_164_ctrl.sv
// hmac_sha256_164_ctrl: drives one shared SHA-256 compression core through HMAC-SHA256 (80B key, 84B msg).
// Latency: hash_done 7L+8 cycles after the accepted start (3L+4 on a key-cache hit); L = core reply delay.
// Backpressure: start is taken only in IDLE; one compression in flight, its block/iv held until core_done.
// Optional build macro HMAC_PRECOMP_EN: caches key + ipad/opad midstates so a repeated key skips KH0/KH1/IN0/OUT0.
module hmac_sha256_164_ctrl #(
  parameter int unsigned CORE_TIMEOUT = 0  // cycles to wait for core_done; 0 disables the watchdog
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [1311:0] data,
  output logic          busy,
  output logic [255:0]  hash,
  output logic          hash_done,
  output logic          err,
  output logic          core_start,
  output logic [511:0]  core_block,
  output logic [255:0]  core_iv,
  input  logic          core_done,
  input  logic [255:0]  core_digest
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_KH0, ST_KH1, ST_IN0, ST_IN1, ST_IN2, ST_OUT0, ST_OUT1, ST_DONE
  } state_e;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] IPAD = {64{8'h36}};
  localparam logic [511:0] OPAD = {64{8'h5c}};

  state_e        state_q, state_d;
  logic [1311:0] data_q, data_d;     // key = [1311:672], msg = [671:0]
  logic [255:0]  chain_q, chain_d;
  logic [255:0]  k0_q, k0_d;         // SHA256(key); the low 256 bits of K0 are zero
  logic [255:0]  inner_q, inner_d;   // inner digest, kept across OUT0
  logic [255:0]  hash_q, hash_d;
  logic [255:0]  iv_q, iv_d;
  logic [511:0]  block_q, block_d;
  logic          busy_q, busy_d;
  logic          hash_done_q, hash_done_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic [31:0]   wait_q, wait_d;
  logic          core_ack;

`ifdef HMAC_PRECOMP_EN
  logic          cache_vld_q, cache_vld_d;
  logic [639:0]  cache_key_q, cache_key_d;
  logic [255:0]  ipad_mid_q, ipad_mid_d;
  logic [255:0]  opad_mid_q, opad_mid_d;
  logic          hit_q, hit_d;       // current run reuses cached midstates
`endif

  // Next state, datapath updates, and the block/iv for a compression state being entered.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    chain_d     = chain_q;
    k0_d        = k0_q;
    inner_d     = inner_q;
    hash_d      = hash_q;
    iv_d        = iv_q;
    block_d     = block_q;
    busy_d      = busy_q;
    hash_done_d = 1'b0;
    err_d       = 1'b0;
    start_d     = 1'b0;
    wait_d      = wait_q;
`ifdef HMAC_PRECOMP_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    ipad_mid_d  = ipad_mid_q;
    opad_mid_d  = opad_mid_q;
    hit_d       = hit_q;
`endif
    // A done coinciding with our own request pulse belongs to nothing we asked for.
    core_ack = core_done && !start_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = data;
          busy_d  = 1'b1;
          state_d = ST_KH0;
`ifdef HMAC_PRECOMP_EN
          hit_d = cache_vld_q && (data[1311:672] == cache_key_q);
          if (hit_d) state_d = ST_IN1;
`endif
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        wait_d = wait_q + 32'd1;
        if (core_ack) begin
          chain_d = core_digest;
          unique case (state_q)
            ST_KH0: state_d = ST_KH1;
            ST_KH1: begin
              k0_d    = core_digest;
              state_d = ST_IN0;
            end
            ST_IN0: begin
              state_d = ST_IN1;
`ifdef HMAC_PRECOMP_EN
              ipad_mid_d = core_digest;
`endif
            end
            ST_IN1: state_d = ST_IN2;
            ST_IN2: begin
              inner_d = core_digest;
              state_d = ST_OUT0;
`ifdef HMAC_PRECOMP_EN
              if (hit_q) state_d = ST_OUT1;
`endif
            end
            ST_OUT0: begin
              state_d = ST_OUT1;
`ifdef HMAC_PRECOMP_EN
              opad_mid_d = core_digest;
`endif
            end
            default: begin  // ST_OUT1: final digest
              hash_d      = core_digest;
              hash_done_d = 1'b1;
              state_d     = ST_DONE;
`ifdef HMAC_PRECOMP_EN
              cache_vld_d = 1'b1;
              cache_key_d = data_q[1311:672];
`endif
            end
          endcase
        end else if (CORE_TIMEOUT != 0 && wait_q == CORE_TIMEOUT) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
`ifdef HMAC_PRECOMP_EN
          cache_vld_d = 1'b0;
          hit_d       = 1'b0;
`endif
        end
      end
    endcase

    if (state_d != state_q && state_d != ST_IDLE && state_d != ST_DONE) begin
      start_d = 1'b1;
      wait_d  = 32'd0;
      iv_d    = chain_d;
      unique case (state_d)
        ST_KH0: begin
          block_d = data_d[1311:800];
          iv_d    = H0;
        end
        ST_KH1:  block_d = {data_d[799:672], 8'h80, 312'd0, 64'd640};
        ST_IN0: begin
          block_d = {k0_d, 256'd0} ^ IPAD;
          iv_d    = H0;
        end
        ST_IN1: begin
          block_d = data_d[671:160];
`ifdef HMAC_PRECOMP_EN
          if (hit_d) iv_d = ipad_mid_q;
`endif
        end
        ST_IN2:  block_d = {data_d[159:0], 8'h80, 280'd0, 64'd1184};
        ST_OUT0: begin
          block_d = {k0_d, 256'd0} ^ OPAD;
          iv_d    = H0;
        end
        default: begin  // ST_OUT1
          block_d = {inner_d, 8'h80, 184'd0, 64'd768};
`ifdef HMAC_PRECOMP_EN
          if (hit_d) iv_d = opad_mid_q;
`endif
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      chain_q     <= '0;
      k0_q        <= '0;
      inner_q     <= '0;
      hash_q      <= '0;
      iv_q        <= '0;
      block_q     <= '0;
      busy_q      <= 1'b0;
      hash_done_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      chain_q     <= chain_d;
      k0_q        <= k0_d;
      inner_q     <= inner_d;
      hash_q      <= hash_d;
      iv_q        <= iv_d;
      block_q     <= block_d;
      busy_q      <= busy_d;
      hash_done_q <= hash_done_d;
      err_q       <= err_d;
      start_q     <= start_d;
      wait_q      <= wait_d;
    end
  end

`ifdef HMAC_PRECOMP_EN
  // Key cache; reset drops it so the first run after reset always rebuilds the midstates.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      ipad_mid_q  <= '0;
      opad_mid_q  <= '0;
      hit_q       <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      ipad_mid_q  <= ipad_mid_d;
      opad_mid_q  <= opad_mid_d;
      hit_q       <= hit_d;
    end
  end
`endif

  assign busy       = busy_q;
  assign hash       = hash_q;
  assign hash_done  = hash_done_q;
  assign err        = err_q;
  assign core_start = start_q;
  assign core_block = block_q;
  assign core_iv    = iv_q;

endmodule

// File: tb/tb_hmac_sha256_164_ctrl.sv
module tb_hmac_sha256_164_ctrl;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [1311:0] data;
  logic          busy;
  logic [255:0]  hash;
  logic          hash_done;
  logic          err;
  logic          core_start;
  logic [511:0]  core_block;
  logic [255:0]  core_iv;
  logic          core_done;
  logic [255:0]  core_digest;

  hmac_sha256_164_ctrl #(.CORE_TIMEOUT(100)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data(data),
    .busy(busy), .hash(hash), .hash_done(hash_done), .err(err),
    .core_start(core_start), .core_block(core_block), .core_iv(core_iv),
    .core_done(core_done), .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stand-in compression function shared by the core model and the reference.
  function automatic logic [255:0] mix(input logic [255:0] iv, input logic [511:0] b);
    logic [255:0] hi, lo;
    hi = b[511:256];
    lo = b[255:0];
    return ((iv ^ hi) + {lo[250:0], lo[255:251]}) ^ {iv[127:0], iv[255:128]} ^ {hi[254:0], 1'b1};
  endfunction

  function automatic logic [255:0] hmac_ref(input logic [1311:0] d);
    logic [639:0] key;
    logic [671:0] msg;
    logic [255:0] k0, ih;
    logic [511:0] k0blk;
    key   = d[1311:672];
    msg   = d[671:0];
    k0    = mix(mix(H0, key[639:128]), {key[127:0], 8'h80, 312'd0, 64'd640});
    k0blk = {k0, 256'd0};
    ih    = mix(H0, k0blk ^ {64{8'h36}});
    ih    = mix(ih, msg[671:160]);
    ih    = mix(ih, {msg[159:0], 8'h80, 280'd0, 64'd1184});
    return mix(mix(H0, k0blk ^ {64{8'h5c}}), {ih, 8'h80, 184'd0, 64'd768});
  endfunction

  function automatic logic [1311:0] mkdata(input logic [31:0] seed);
    logic [1311:0] d;
    for (int i = 0; i < 41; i++)
      d[i*32 +: 32] = (32'(i + 1) * 32'h9e3779b9) ^ seed ^ {seed[15:0], seed[31:16]};
    return d;
  endfunction

  // ---------------- core model ----------------
  int            lat = 64;
  bit            core_mute = 1'b0;
  bit            glitch_en = 1'b0;
  int            inj_req = 0;
  int            nstart = 0;
  logic [511:0]  blk_log[$];

  initial begin
    int due;
    bit pend;
    int ack;
    logic [511:0] bl;
    logic [255:0] ivl;
    due = 0; pend = 1'b0; ack = 0; bl = '0; ivl = '0;
    core_done = 1'b0;
    core_digest = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!n_rst) begin
        pend = 1'b0;
      end else begin
        if (pend && cyc == due) begin
          chk("core_block_stable", core_block, bl);
          chk("core_iv_stable", 512'(core_iv), 512'(ivl));
          core_done = 1'b1;
          core_digest = mix(ivl, bl);
          pend = 1'b0;
        end
        if (inj_req != ack) begin
          ack = inj_req;
          core_done = 1'b1;
          core_digest = '1;
        end
        if (core_start) begin
          nstart++;
          bl = core_block;
          ivl = core_iv;
          blk_log.push_back(bl);
          if (!core_mute) begin
            pend = 1'b1;
            due = cyc + lat;
          end
          if (glitch_en) begin
            core_done = 1'b1;
            core_digest = '1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit           is_err;
    logic [255:0] hash;
    int           due;
    string        name;
  } exp_t;
  exp_t sb[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && (hash_done === 1'b1 || err === 1'b1)) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: hash_done=%0b err=%0b at cycle %0d, none expected", hash_done, err, cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_kind_err"}, 512'(err), 512'(e.is_err));
          chk({e.name, "_hash"}, 512'(hash), 512'(e.hash));
          chk({e.name, "_cycle"}, 512'(cyc), 512'(e.due));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit           c_ok = 1'b0;
  logic [639:0] c_key = '0;
  logic [255:0] last_hash = '0;

  task automatic wait_idle(input string nm, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle: busy still %b after %0d cycles", nm, busy, budget);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, 512'(busy), 512'(0));
    chk({nm, "_hash"}, 512'(hash), 512'(0));
    chk({nm, "_hash_done"}, 512'(hash_done), 512'(0));
    chk({nm, "_err"}, 512'(err), 512'(0));
    chk({nm, "_core_start"}, 512'(core_start), 512'(0));
    chk({nm, "_core_block"}, core_block, 512'(0));
    chk({nm, "_core_iv"}, 512'(core_iv), 512'(0));
  endtask

  function automatic int exp_starts(input logic [1311:0] d);
`ifdef HMAC_PRECOMP_EN
    if (c_ok && d[1311:672] == c_key) return 3;
`endif
    return 7;
  endfunction

  task automatic run_full(input string nm, input logic [1311:0] d, input int L);
    exp_t e;
    int s0, ns;
    lat = L;
    ns = exp_starts(d);
    s0 = nstart;
    @(negedge clk);
    e.is_err = 1'b0;
    e.hash = hmac_ref(d);
    e.due = cyc + ((ns == 3) ? 3 * L + 4 : 7 * L + 8);
    e.name = nm;
    sb.push_back(e);
    start = 1'b1;
    data = d;
    @(negedge clk);
    start = 1'b0;
    wait_idle(nm, 8 * L + 50);
    chk({nm, "_nstarts"}, 512'(nstart - s0), 512'(ns));
    c_ok = 1'b1;
    c_key = d[1311:672];
    last_hash = e.hash;
  endtask

  initial begin
    logic [1311:0] d1, d2, d3, d4, tmpd;
    logic [511:0] b;
    int base, s0, k;
    exp_t e;

    d1 = mkdata(32'h243f6a88);
    tmpd = mkdata(32'h0badcafe);
    d2 = {d1[1311:672], tmpd[671:0]};
    d3 = mkdata(32'h13198a2e);
    d4 = mkdata(32'ha4093822);

    start = 1'b0;
    data = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Full run, L=64, plus block contents of the padded blocks.
    base = blk_log.size();
    run_full("run_l64", d1, 64);
    b = blk_log[base];
    chk("kh0_block", b, 512'(d1[1311:800]));
    b = blk_log[base + 1];
    chk("kh1_pad80", 512'(b[383:376]), 512'(8'h80));
    chk("kh1_len", 512'(b[63:0]), 512'(640));
    b = blk_log[base + 2];
    chk("in0_ipad_low", 512'(b[255:0]), 512'({32{8'h36}}));
    b = blk_log[base + 4];
    chk("in2_pad80", 512'(b[351:344]), 512'(8'h80));
    chk("in2_len", 512'(b[63:0]), 512'(1184));
    b = blk_log[base + 6];
    chk("out1_pad80", 512'(b[255:248]), 512'(8'h80));
    chk("out1_len", 512'(b[63:0]), 512'(768));

    // Same key, new message: repeat-key path (shortened when the cache is built in).
    run_full("same_key", d2, 64);

    // start held every cycle while busy, data churning: one result, from the latched data.
    lat = 3;
    s0 = nstart;
    @(negedge clk);
    e.is_err = 1'b0;
    e.hash = hmac_ref(d3);
    e.due = cyc + 7 * 3 + 8;
    e.name = "start_spam";
    sb.push_back(e);
    start = 1'b1;
    data = d3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      data = mkdata(32'(100 + k));
      start = busy;
    end while (busy === 1'b1 && k < 200);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("start_spam_nstarts", 512'(nstart - s0), 512'(7));
    chk("start_spam_idle", 512'(busy), 512'(0));
    c_ok = 1'b1;
    c_key = d3[1311:672];
    last_hash = e.hash;

    // core_done on the same cycle as core_start must be ignored.
    glitch_en = 1'b1;
    run_full("same_cycle_done", d4, 2);
    glitch_en = 1'b0;

    // core_done while idle must be ignored.
    inj_req++;
    repeat (3) @(negedge clk);
    chk("idle_done_busy", 512'(busy), 512'(0));
    chk("idle_done_hash", 512'(hash), 512'(last_hash));

    // Reset during IN1, then a fresh run.
    lat = 10;
    s0 = nstart;
    @(negedge clk);
    start = 1'b1;
    data = d1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (nstart - s0 < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_in1", 512'(nstart - s0 >= 4), 512'(1));
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    c_ok = 1'b0;
    last_hash = '0;
    n_rst = 1'b1;
    @(negedge clk);
    run_full("after_reset", d2, 5);

    // Core never answers: err at cycle 102 (101 after the first core_start), hash kept.
    core_mute = 1'b1;
    s0 = nstart;
    @(negedge clk);
    e.is_err = 1'b1;
    e.hash = last_hash;
    e.due = cyc + 102;
    e.name = "timeout";
    sb.push_back(e);
    start = 1'b1;
    data = d3;
    @(negedge clk);
    start = 1'b0;
    wait_idle("timeout", 300);
    @(negedge clk);
    chk("timeout_busy_after", 512'(busy), 512'(0));
    chk("timeout_err_one_cycle", 512'(err), 512'(0));
    chk("timeout_hash_kept", 512'(hash), 512'(last_hash));
    chk("timeout_nstarts", 512'(nstart - s0), 512'(1));
    core_mute = 1'b0;
    c_ok = 1'b0;

    // Recovery run after the abort, fastest core.
    run_full("after_timeout", d1, 1);

    repeat (10) @(negedge clk);
    chk("sb_drained", 512'(sb.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "global timeout");
  end

endmodule
